// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter for one shared 4:1 mux: one-hot grant, mux select and a registered sample of the selected bit.
// Latency: a grant appears 1 edge after the winning request; y/y_valid follow 1 edge after each granted cycle.
// Backpressure: none; an owner keeps the grant until it drops req or reaches MAX_HOLD consecutive cycles.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req[3:0]        per-requester request
//   a[3:0]          mux data inputs, a[i] belongs to requester i
//   grant[3:0]      registered one-hot grant, zero when idle
//   s[1:0]          registered mux select, the index of the grant bit
//   busy            |grant
//   y, y_valid      registered a[s] and its strobe for the previous granted cycle
module mux_4to1_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] a,
    output logic [3:0] grant,
    output logic [1:0] s,
    output logic       busy,
    output logic       y,
    output logic       y_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]        grant_q, grant_d;
    logic [1:0]        s_q, s_d;
    logic              y_q, y_d;
    logic              y_valid_q, y_valid_d;

    logic [1:0]        arb_start;
    logic [1:0]        scan_idx;
    logic              arb_found;
    logic [1:0]        arb_win;
    logic              release_own;

    // The scan start is the stored pointer when idle, or owner+1 while owning.
    // In OWN the result is only used on a release, where ptr becomes owner+1
    // in the same cycle, so both cases scan from the pointer in effect.
    always_comb begin
        arb_start = (state_q == OWN) ? s_q + 2'd1 : ptr_q;
        arb_found = 1'b0;
        arb_win   = 2'd0;
        scan_idx  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = arb_start + 2'(k);
            if (!arb_found && req[scan_idx]) begin
                arb_found = 1'b1;
                arb_win   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        s_d        = s_q;
        y_d        = y_q;
        y_valid_d  = 1'b0;

        // Drop of req and hitting the cap in the same cycle is one release.
        release_own = (state_q == OWN) &&
                      (!req[s_q] || (hold_cnt_q == HOLD_MAX));

        // Sample the mux on every granted cycle, including the owner's last one.
        if (grant_q != 4'b0000) begin
            y_d       = a[s_q];
            y_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d    = 4'b0001 << arb_win;
                    s_d        = arb_win;
                    hold_cnt_d = HOLD_W'(1);
                    state_d    = OWN;
                end
            end
            OWN: begin
                if (release_own) begin
                    ptr_d = s_q + 2'd1;
                    if (arb_found) begin
                        // Back-to-back handover, possibly to the same owner.
                        grant_d    = 4'b0001 << arb_win;
                        s_d        = arb_win;
                        hold_cnt_d = HOLD_W'(1);
                    end else begin
                        grant_d    = 4'b0000;
                        hold_cnt_d = '0;
                        state_d    = IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
            grant_q    <= 4'b0000;
            s_q        <= 2'd0;
            y_q        <= 1'b0;
            y_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            s_q        <= s_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
        end
    end

    assign grant   = grant_q;
    assign s       = s_q;
    assign busy    = |grant_q;
    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule
